// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
//   Parses binary command frames arriving on the UART receive byte stream
//   into single-cycle register read/write strobes, and returns reply frames
//   on the UART transmit byte stream.
//
//   Frame: 0xA5, OP, ADDR, [DATA_BYTES bytes MSB first when OP=0x01], CSUM
//   CSUM is the XOR of every byte after the header.
//   Replies: ACK 0x06 (write), NAK 0x15 (bad frame / receive error),
//            0xA5 + data MSB first + XOR of data bytes (read).
//
// Ports
//   clk, reset           system clock, asynchronous active-low reset
//   from_uart_*          receive stream (data/error/valid in, ready out)
//   to_uart_*            transmit stream (data/error/valid out, ready in)
//   reg_addr/reg_wdata   register address and write data, held between strobes
//   reg_we/reg_re        one-cycle write/read strobes
//   reg_rdata            read data, sampled one cycle after reg_re
module uart_cmd_bridge #(
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              from_uart_data,
    input  logic                    from_uart_error,
    input  logic                    from_uart_valid,
    output logic                    from_uart_ready,
    output logic [7:0]              to_uart_data,
    output logic                    to_uart_error,
    output logic                    to_uart_valid,
    input  logic                    to_uart_ready,
    output logic [7:0]              reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    output logic                    reg_we,
    output logic                    reg_re,
    input  logic [8*DATA_BYTES-1:0] reg_rdata
);
    localparam int DW  = 8 * DATA_BYTES;
    localparam int TXW = 8 * (DATA_BYTES + 2);      // longest reply: header + data + csum
    localparam int CW  = $clog2(DATA_BYTES + 3);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]     SOF   = 8'hA5;
    localparam logic [7:0]     OP_WR = 8'h01;
    localparam logic [7:0]     OP_RD = 8'h02;
    localparam logic [7:0]     ACK   = 8'h06;
    localparam logic [7:0]     NAK   = 8'h15;
    localparam logic [TXW-9:0] PAD   = '0;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HDR, S_OP, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RDWAIT, S_TX
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [7:0]      addr_q, addr_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [7:0]      xor_q, xor_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [TXW-1:0]  tx_q, tx_d;          // reply bytes, next byte to send in the top byte
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;  // reply bytes still to send
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
    logic [7:0]      rd_csum;
    logic            rx_fire, tx_fire;

    assign from_uart_ready = (state_q == S_HDR) || (state_q == S_OP) || (state_q == S_ADDR)
                          || (state_q == S_DATA) || (state_q == S_CSUM);
    assign to_uart_valid   = (state_q == S_TX);
    assign to_uart_data    = tx_q[TXW-1 -: 8];
    assign to_uart_error   = 1'b0;
    assign reg_we          = (state_q == S_EXEC) && (op_q == OP_WR);
    assign reg_re          = (state_q == S_EXEC) && (op_q == OP_RD);
    assign reg_addr        = reg_addr_q;
    assign reg_wdata       = reg_wdata_q;

    assign rx_fire = from_uart_valid && from_uart_ready;
    assign tx_fire = to_uart_valid && to_uart_ready;

    always_comb begin
        rd_csum = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            rd_csum = rd_csum ^ reg_rdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        xor_d       = xor_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;                 // the idle counter only runs mid-frame
        tx_d        = tx_q;
        tx_cnt_d    = tx_cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;

        case (state_q)
            S_HDR: begin
                if (rx_fire && !from_uart_error && (from_uart_data == SOF)) begin
                    state_d = S_OP;
                end
            end
            S_OP, S_ADDR, S_DATA, S_CSUM: begin
                if (rx_fire) begin
                    if (from_uart_error) begin
                        tx_d     = {NAK, PAD};
                        tx_cnt_d = CW'(1);
                        state_d  = S_TX;
                    end else if (state_q == S_OP) begin
                        op_d    = from_uart_data;
                        xor_d   = from_uart_data;
                        state_d = S_ADDR;
                    end else if (state_q == S_ADDR) begin
                        addr_d  = from_uart_data;
                        xor_d   = xor_q ^ from_uart_data;
                        cnt_d   = '0;
                        state_d = (op_q == OP_WR) ? S_DATA : S_CSUM;
                    end else if (state_q == S_DATA) begin
                        shift_d = DW'({shift_q, from_uart_data});
                        xor_d   = xor_q ^ from_uart_data;
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CW'(DATA_BYTES - 1)) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        if ((from_uart_data == xor_q) && ((op_q == OP_WR) || (op_q == OP_RD))) begin
                            // Register outputs only move on a frame that will execute.
                            state_d    = S_EXEC;
                            reg_addr_d = addr_q;
                            if (op_q == OP_WR) begin
                                reg_wdata_d = shift_q;
                            end
                        end else begin
                            tx_d     = {NAK, PAD};
                            tx_cnt_d = CW'(1);
                            state_d  = S_TX;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HDR;      // stale partial frame, dropped silently
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_EXEC: begin
                if (op_q == OP_WR) begin
                    tx_d     = {ACK, PAD};
                    tx_cnt_d = CW'(1);
                    state_d  = S_TX;
                end else begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                tx_d     = {SOF, reg_rdata, rd_csum};
                tx_cnt_d = CW'(DATA_BYTES + 2);
                state_d  = S_TX;
            end
            S_TX: begin
                if (tx_fire) begin
                    tx_d     = tx_q << 8;
                    tx_cnt_d = tx_cnt_q - CW'(1);
                    if (tx_cnt_q == CW'(1)) begin
                        state_d = S_HDR;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HDR;
            op_q        <= '0;
            addr_q      <= '0;
            shift_q     <= '0;
            xor_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            tx_q        <= '0;
            tx_cnt_q    <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            xor_q       <= xor_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            tx_q        <= tx_d;
            tx_cnt_q    <= tx_cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
module tb_uart_cmd_bridge;
    localparam int DB = 4;
    localparam int T  = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  from_uart_data;
    logic        from_uart_error;
    logic        from_uart_valid;
    logic        from_uart_ready;
    logic [7:0]  to_uart_data;
    logic        to_uart_error;
    logic        to_uart_valid;
    logic        to_uart_ready;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;

    uart_cmd_bridge #(.DATA_BYTES(DB), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .from_uart_data(from_uart_data), .from_uart_error(from_uart_error),
        .from_uart_valid(from_uart_valid), .from_uart_ready(from_uart_ready),
        .to_uart_data(to_uart_data), .to_uart_error(to_uart_error),
        .to_uart_valid(to_uart_valid), .to_uart_ready(to_uart_ready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] data;
    } stb_t;

    // Model state: expected register file contents, expected strobes/reply bytes.
    logic [31:0] exp_mem [256];
    logic [31:0] rf [256];          // register file the bench presents to the DUT
    stb_t        exp_stb[$];
    stb_t        stb_log[$];
    logic [7:0]  exp_reply[$];
    logic [7:0]  reply_log[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    int tx_last_cyc = -10;
    int sent_in_reply = 0;
    bit bp_arm = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    // Always entered at posedge+1: the byte is accepted on the first edge with ready=1.
    task automatic send_byte(input logic [7:0] b, input logic err);
        int n;
        bit waited;
        from_uart_data  = b;
        from_uart_error = err;
        from_uart_valid = 1'b1;
        n = 0;
        waited = 0;
        @(negedge clk);
        while (!from_uart_ready && n < 500) begin
            waited = 1;
            @(negedge clk);
            n++;
        end
        chk("rx_accept_bound", from_uart_ready, 1'b1);
        last_acc = cyc + 1;
        if (waited) chk("b2b_accept_cycle", last_acc, tx_last_cyc + 1);
        @(posedge clk);
        #1;
        from_uart_valid = 1'b0;
        from_uart_error = 1'b0;
    endtask

    // Works out from the frame bytes what the bridge must do, queues it, then sends.
    task automatic send_frame(input string nm, input logic [63:0] bytes, input int n,
                              input int err_idx, input int gap);
        logic [7:0]  b [8];
        logic [7:0]  x;
        logic [31:0] d;
        int          flen;
        stb_t        s;
        for (int i = 0; i < 8; i++) b[i] = 8'h00;
        for (int i = 0; i < n; i++) b[i] = bytes[8*(n-1-i) +: 8];
        flen = (b[1] == 8'h01) ? 3 + DB + 1 : 4;
        if (err_idx >= 1 && err_idx < n) begin
            exp_reply.push_back(8'h15);
        end else if (n >= flen) begin
            x = 8'h00;
            for (int i = 1; i < flen - 1; i++) x = x ^ b[i];
            if (b[flen-1] != x || !(b[1] == 8'h01 || b[1] == 8'h02)) begin
                exp_reply.push_back(8'h15);
            end else if (b[1] == 8'h01) begin
                d = {b[3], b[4], b[5], b[6]};
                exp_mem[b[2]] = d;
                s.rd = 1'b0; s.addr = b[2]; s.data = d;
                exp_stb.push_back(s);
                exp_reply.push_back(8'h06);
            end else begin
                d = exp_mem[b[2]];
                s.rd = 1'b1; s.addr = b[2]; s.data = 32'h0;
                exp_stb.push_back(s);
                exp_reply.push_back(8'hA5);
                for (int k = 3; k >= 0; k--) exp_reply.push_back(d[8*k +: 8]);
                exp_reply.push_back(d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
            end
        end
        $display("frame %s: %0d bytes %0h err_idx=%0d gap=%0d", nm, n, bytes, err_idx, gap);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], (i == err_idx));
            if (i != n - 1 && gap > 0) tick(gap);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_reply.size() != 0 || exp_stb.size() != 0 || to_uart_valid) && n < 1000) begin
            tick(1);
            n++;
        end
        chk("drain_expectations", exp_reply.size() + exp_stb.size(), 0);
        tick(3);
    endtask

    task automatic check_reply(input string nm, input int n, input logic [63:0] exp);
        chk({nm, "_len"}, reply_log.size(), n);
        for (int i = 0; i < n && i < reply_log.size(); i++) begin
            chk($sformatf("%s_byte%0d", nm, i), reply_log[i], exp[8*(n-1-i) +: 8]);
        end
        reply_log.delete();
    endtask

    task automatic check_stb(input string nm, input int n, input logic rd,
                             input logic [7:0] addr, input logic [31:0] data);
        chk({nm, "_count"}, stb_log.size(), n);
        if (n > 0 && stb_log.size() > 0) begin
            chk({nm, "_kind"}, stb_log[0].rd, rd);
            chk({nm, "_addr"}, stb_log[0].addr, addr);
            if (!rd) chk({nm, "_wdata"}, stb_log[0].data, data);
        end
        stb_log.delete();
    endtask

    // Register file behind the bridge: read data is only valid during the cycle after reg_re.
    initial begin
        logic [7:0] a;
        reg_rdata = 32'h0BADF00D;
        forever begin
            @(negedge clk);
            if (reset && reg_we) rf[reg_addr] = reg_wdata;
            if (reset && reg_re) begin
                a = reg_addr;
                @(posedge clk);
                #1 reg_rdata = rf[a];
                @(posedge clk);
                #1 reg_rdata = 32'h0BADF00D;
            end
        end
    end

    // Reply sink with optional 10-cycle stall on the second reply byte.
    initial begin
        to_uart_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_arm && to_uart_valid && sent_in_reply == 1) begin
                bp_arm = 0;
                to_uart_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk("bp_hold_data", to_uart_data, 8'hDE);
                chk("bp_rx_ready", from_uart_ready, 1'b0);
                repeat (5) @(posedge clk);
                #1 to_uart_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model queues.
    initial begin
        logic       prev_valid;
        logic       prev_stall;
        logic [7:0] prev_data;
        bit         stb_pending;
        int         stb_cyc;
        logic       stb_rd;
        stb_t       e;
        stb_t       got;
        prev_valid = 0; prev_stall = 0; prev_data = 0;
        stb_pending = 0; stb_cyc = 0; stb_rd = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 0; prev_stall = 0; stb_pending = 0; sent_in_reply = 0;
            end else begin
                if (reg_we || reg_re) begin
                    chk("single_strobe", reg_we & reg_re, 1'b0);
                    chk("strobe_latency", cyc, last_acc);
                    got.rd = reg_re; got.addr = reg_addr; got.data = reg_wdata;
                    stb_log.push_back(got);
                    if (exp_stb.size() == 0) begin
                        chk("unexpected_strobe", exp_stb.size(), 1);
                    end else begin
                        e = exp_stb.pop_front();
                        chk("strobe_kind", reg_re, e.rd);
                        chk("strobe_addr", reg_addr, e.addr);
                        if (!e.rd) chk("strobe_wdata", reg_wdata, e.data);
                    end
                    stb_pending = 1; stb_cyc = cyc; stb_rd = reg_re;
                end
                if (prev_stall) begin
                    chk("tx_valid_hold", to_uart_valid, 1'b1);
                    chk("tx_data_hold", to_uart_data, prev_data);
                end
                if (to_uart_valid) begin
                    chk("rx_ready_low_in_tx", from_uart_ready, 1'b0);
                    if (!prev_valid && stb_pending) begin
                        chk("reply_latency", cyc, stb_cyc + (stb_rd ? 2 : 1));
                        stb_pending = 0;
                    end
                    if (to_uart_ready) begin
                        chk("tx_error_zero", to_uart_error, 1'b0);
                        if (exp_reply.size() == 0) chk("unexpected_reply", exp_reply.size(), 1);
                        else chk("reply_byte", to_uart_data, exp_reply.pop_front());
                        reply_log.push_back(to_uart_data);
                        tx_last_cyc = cyc + 1;
                        sent_in_reply++;
                    end
                end else begin
                    sent_in_reply = 0;
                end
                prev_valid = to_uart_valid;
                prev_stall = to_uart_valid && !to_uart_ready;
                prev_data  = to_uart_data;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = {i[7:0], 8'h5A, ~i[7:0], 8'hC3};
            rf[i]      = exp_mem[i];
        end
        exp_mem[8'h20] = 32'hDEADBEEF;
        rf[8'h20]      = 32'hDEADBEEF;

        reset = 1'b0;
        from_uart_data = 8'h00; from_uart_error = 1'b0; from_uart_valid = 1'b0;
        tick(3);
        chk("rst_rx_ready", from_uart_ready, 1'b1);
        chk("rst_tx_valid", to_uart_valid, 1'b0);
        chk("rst_tx_data", to_uart_data, 8'h00);
        chk("rst_tx_error", to_uart_error, 1'b0);
        chk("rst_strobes", {reg_we, reg_re}, 2'b00);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wdata", reg_wdata, 32'h0);
        reset = 1'b1;
        tick(2);

        send_frame("write_10", 64'hA5_01_10_12_34_56_78_19, 8, -1, 0);
        wait_idle();
        check_reply("write_10_reply", 1, 64'h06);
        check_stb("write_10_stb", 1, 1'b0, 8'h10, 32'h12345678);

        send_frame("read_20", 64'hA5_02_20_22, 4, -1, 0);
        wait_idle();
        check_reply("read_20_reply", 6, 64'hA5_DE_AD_BE_EF_22);
        check_stb("read_20_stb", 1, 1'b1, 8'h20, 32'h0);

        bp_arm = 1;
        send_frame("read_20_bp", 64'hA5_02_20_22, 4, -1, 0);
        wait_idle();
        chk("bp_stall_taken", bp_arm, 1'b0);
        check_reply("read_20_bp_reply", 6, 64'hA5_DE_AD_BE_EF_22);
        check_stb("read_20_bp_stb", 1, 1'b1, 8'h20, 32'h0);

        send_frame("read_10", 64'hA5_02_10_12, 4, -1, 0);
        wait_idle();
        check_reply("read_10_reply", 6, 64'hA5_12_34_56_78_08);
        check_stb("read_10_stb", 1, 1'b1, 8'h10, 32'h0);

        send_frame("bad_csum", 64'hA5_01_10_12_34_56_78_18, 8, -1, 0);
        wait_idle();
        check_reply("bad_csum_reply", 1, 64'h15);
        check_stb("bad_csum_stb", 0, 1'b0, 8'h0, 32'h0);

        send_frame("bad_op", 64'hA5_07_10_17, 4, -1, 0);
        wait_idle();
        check_reply("bad_op_reply", 1, 64'h15);
        check_stb("bad_op_stb", 0, 1'b0, 8'h0, 32'h0);

        send_frame("timeout_partial", 64'hA5_01, 2, -1, 0);
        tick(T + 5);
        wait_idle();
        chk("timeout_rx_ready", from_uart_ready, 1'b1);
        check_reply("timeout_reply", 0, 64'h0);
        check_stb("timeout_stb", 0, 1'b0, 8'h0, 32'h0);

        send_frame("write_44", 64'hA5_01_44_CA_FE_00_01_70, 8, -1, 0);
        wait_idle();
        check_reply("write_44_reply", 1, 64'h06);
        check_stb("write_44_stb", 1, 1'b0, 8'h44, 32'hCAFE0001);
        chk("hold_reg_addr", reg_addr, 8'h44);
        chk("hold_reg_wdata", reg_wdata, 32'hCAFE0001);

        send_frame("err_on_addr", 64'hA5_01_10, 3, 2, 0);
        wait_idle();
        check_reply("err_on_addr_reply", 1, 64'h15);
        check_stb("err_on_addr_stb", 0, 1'b0, 8'h0, 32'h0);
        chk("nak_keeps_reg_addr", reg_addr, 8'h44);
        chk("nak_keeps_reg_wdata", reg_wdata, 32'hCAFE0001);

        send_frame("write_55_gaps", 64'hA5_01_55_00_00_00_00_54, 8, -1, T - 3);
        wait_idle();
        check_reply("write_55_reply", 1, 64'h06);
        check_stb("write_55_stb", 1, 1'b0, 8'h55, 32'h0);

        send_frame("b2b_write_60", 64'hA5_01_60_11_22_33_44_25, 8, -1, 0);
        send_frame("b2b_read_60", 64'hA5_02_60_62, 4, -1, 0);
        wait_idle();
        check_reply("b2b_reply", 7, 64'h06_A5_11_22_33_44_44);
        check_stb("b2b_stb", 2, 1'b0, 8'h60, 32'h11223344);

        send_frame("partial_before_reset", 64'hA5_01_30_AA_BB, 5, -1, 0);
        #3 reset = 1'b0;
        tick(2);
        chk("midrst_rx_ready", from_uart_ready, 1'b1);
        chk("midrst_tx_valid", to_uart_valid, 1'b0);
        chk("midrst_reg_addr", reg_addr, 8'h00);
        chk("midrst_reg_wdata", reg_wdata, 32'h0);
        reset = 1'b1;
        tick(2);
        send_frame("write_31_after_reset", 64'hA5_01_31_01_02_03_04_34, 8, -1, 0);
        wait_idle();
        check_reply("write_31_reply", 1, 64'h06);
        check_stb("write_31_stb", 1, 1'b0, 8'h31, 32'h01020304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Sits on the far side of the RS232 core's byte streams.
- Consumes the receive stream (from_uart_*) and parses binary command frames into single-cycle register read/write strobes.
- Produces the reply frames on the transmit stream (to_uart_*).
- Gives host software register access to SDR control logic over the serial link.

Parameters:
DATA_BYTES, 4, register data width in bytes (DW = 8*DATA_BYTES); range 1..4
TIMEOUT_CYCLES, 50000, idle clk cycles allowed between bytes of one frame before the partial frame is discarded

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
from_uart_data  in  8  received byte
from_uart_error  in  1  framing/parity error flag, qualified by from_uart_valid
from_uart_valid  in  1  received byte valid
from_uart_ready  out  1  bridge accepts a byte this cycle
to_uart_data  out  8  reply byte
to_uart_error  out  1  always 0
to_uart_valid  out  1  reply byte valid
to_uart_ready  in  1  UART accepts a reply byte
reg_addr  out  8  register address, valid with reg_we/reg_re
reg_wdata  out  DW  write data, valid with reg_we
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  DW  read data, sampled exactly 1 cycle after reg_re

Behaviour:
- Reset (async assert, sync release): state HDR; all outputs 0 except from_uart_ready=1. Reset mid-frame or mid-reply drops the frame and any unsent reply bytes.
- Transfer rules:
  - A byte is accepted when from_uart_valid && from_uart_ready.
  - A reply byte is sent when to_uart_valid && to_uart_ready.
  - to_uart_data holds stable while to_uart_valid=1 and to_uart_ready=0.
- Frame format: 0xA5, OP, ADDR, [DATA_BYTES bytes, MSB first, only when OP=0x01], CSUM.
  - CSUM = XOR of OP, ADDR and any data bytes. The header is excluded.
- States:
  - HDR: ready=1. Byte 0xA5 -> OP. Any other byte is discarded silently.
  - OP: store opcode -> ADDR.
  - ADDR: store address -> DATA if OP=0x01, else CSUM.
  - DATA: shift byte into the wdata register; after DATA_BYTES bytes -> CSUM.
  - CSUM: compare against the running XOR.
    - Mismatch, or OP not in {0x01, 0x02}: queue NAK (0x15) -> TX.
    - Match with OP=0x01: -> EXEC.
    - Match with OP=0x02: -> EXEC.
  - EXEC: one cycle; ready=0.
    - Write: reg_we=1; queue ACK (0x06) -> TX.
    - Read: reg_re=1 -> RDWAIT.
  - RDWAIT: one cycle; capture reg_rdata. Queue 0xA5, data bytes MSB first, then the XOR of the data bytes -> TX.
  - TX: ready=0. Send queued bytes in order; after the last byte is accepted -> HDR.
- from_uart_ready is 1 only in HDR, OP, ADDR, DATA, CSUM.
- Latency: reg_we/reg_re assert in the cycle after the CSUM byte is accepted. The first reply byte is valid on the cycle after EXEC (write) or RDWAIT (read).
- Receive errors:
  - Byte accepted with from_uart_error=1 in OP..CSUM: abort frame, no strobes, queue NAK -> TX.
  - Error byte in HDR: discarded, no NAK.
- Timeout:
  - The counter clears on every accepted byte and runs only in OP..CSUM.
  - When it reaches TIMEOUT_CYCLES-1: -> HDR, no reply, no strobes.
  - The counter saturates, and the check happens before wrap-around.
- reg_addr/reg_wdata hold their last value outside strobes.
- Strobes never assert outside EXEC, and at most one strobe fires per frame.
- Back-to-back frames: a byte offered while in TX is not accepted. It is accepted in HDR on the first cycle after the reply completes.

Test Plan:
- Write, DATA_BYTES=4: A5 01 10 12 34 56 78 19 -> one reg_we cycle with reg_addr=0x10, reg_wdata=0x12345678; reply 06.
- Read: A5 02 20 22, reg_rdata=0xDEADBEEF on the cycle after reg_re -> reg_re pulse with reg_addr=0x20; reply A5 DE AD BE EF 22.
- Bad checksum: A5 01 10 12 34 56 78 18 -> no reg_we; reply 15. Bad opcode: A5 07 10 17 -> reply 15, no strobes.
- Timeout: A5 01, then idle TIMEOUT_CYCLES cycles -> no reply, no strobes; the write frame above sent next completes normally (reply 06).
- Backpressure: during the read reply, hold to_uart_ready=0 for 10 cycles at byte 2 -> to_uart_data=0xDE held stable, from_uart_ready=0; the full reply A5 DE AD BE EF 22 arrives intact.
- Error/reset:
  - from_uart_error=1 on the ADDR byte -> reply 15, no strobes.
  - Assert reset during DATA, release, send a valid write -> only the new write executes.
